// File: rtl/uio_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uio_serial_tx
//  Purpose  : Byte-wide UART-style serial transmitter. Accepts a parallel byte
//             with a valid/ready handshake and shifts it out LSB first on a
//             single line: start bit, 8 data bits, optional even parity bit,
//             then one or two stop bits.
//  Ports    : clk       - system clock, rising-edge active
//             rst       - asynchronous active-high reset
//             tx_data   - byte to send, sampled only on acceptance
//             tx_valid  - producer has a byte available
//             tx_ready  - transmitter can accept a byte this cycle
//             tx_serial - serial line (idle/stop = 1, start = 0)
//             tx_busy   - a frame is in progress
//             tx_done   - one-cycle pulse on the first idle cycle after a frame
//  Revision : 1.0 - initial release
// ============================================================================
module uio_serial_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  generate
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 255) begin : g_bad_clks_per_bit
      $error("uio_serial_tx: CLKS_PER_BIT must be in 2..255");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uio_serial_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_parity_en
      $error("uio_serial_tx: PARITY_EN must be 0 or 1");
    end
  endgenerate

  localparam int                C_BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [C_BAUD_W-1:0] C_BAUD_LAST = C_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [C_BAUD_W-1:0] C_BAUD_ONE  = C_BAUD_W'(1);
  localparam logic [2:0]        C_STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t              state_q,  state_d;
  logic [C_BAUD_W-1:0] baud_q,   baud_d;
  logic [2:0]          bit_q,    bit_d;     // data bit index, reused as stop-bit index
  logic [7:0]          shreg_q,  shreg_d;
  logic                par_q,    par_d;
  logic                serial_q, serial_d;
  logic                ready_q,  ready_d;
  logic                busy_q,   busy_d;
  logic                done_q,   done_d;

  logic w_baud_last;
  assign w_baud_last = (baud_q == C_BAUD_LAST);

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      serial_q <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Every output is computed here from the next state so
  // that the registered line value changes on the same edge as the state.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    serial_d = serial_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        serial_d = 1'b1;
        baud_d   = '0;
        bit_d    = '0;
        if (tx_valid && ready_q) begin
          shreg_d  = tx_data;
          par_d    = ^tx_data;
          state_d  = S_START;
          serial_d = 1'b0;
        end
      end

      S_START: begin
        if (w_baud_last) begin
          baud_d   = '0;
          state_d  = S_DATA;
          serial_d = shreg_q[0];
        end else begin
          baud_d = baud_q + C_BAUD_ONE;
        end
      end

      S_DATA: begin
        if (w_baud_last) begin
          baud_d  = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              state_d  = S_PARITY;
              serial_d = par_q;
            end else begin
              state_d  = S_STOP;
              serial_d = 1'b1;
            end
          end else begin
            bit_d    = bit_q + 3'd1;
            // Next bit is the one about to land in shreg_q[0] after the shift.
            serial_d = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + C_BAUD_ONE;
        end
      end

      S_PARITY: begin
        if (w_baud_last) begin
          baud_d   = '0;
          state_d  = S_STOP;
          serial_d = 1'b1;
        end else begin
          baud_d = baud_q + C_BAUD_ONE;
        end
      end

      S_STOP: begin
        serial_d = 1'b1;
        if (w_baud_last) begin
          baud_d = '0;
          if (bit_q == C_STOP_LAST) begin
            bit_d   = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + C_BAUD_ONE;
        end
      end

      default: begin
        state_d  = S_IDLE;
        baud_d   = '0;
        bit_d    = '0;
        serial_d = 1'b1;
      end
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  assign tx_ready  = ready_q;
  assign tx_serial = serial_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uio_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uio_serial_tx
//  Purpose  : Self-checking bench for uio_serial_tx. Two instances are used:
//             a (CLKS_PER_BIT=4, no parity, 1 stop) and p (CLKS_PER_BIT=4,
//             even parity, 2 stop bits). Single frames come from a vector
//             table; back-to-back, accept-while-busy and async reset are
//             hand-written sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uio_serial_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_data,  p_data;
  logic       a_valid, p_valid;
  logic       a_ready, a_serial, a_busy, a_done;
  logic       p_ready, p_serial, p_busy, p_done;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uio_serial_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (a_data),
    .tx_valid (a_valid),
    .tx_ready (a_ready),
    .tx_serial(a_serial),
    .tx_busy  (a_busy),
    .tx_done  (a_done)
  );

  uio_serial_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) dut_p (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (p_data),
    .tx_valid (p_valid),
    .tx_ready (p_ready),
    .tx_serial(p_serial),
    .tx_busy  (p_busy),
    .tx_done  (p_done)
  );

  typedef struct {
    bit         sel;        // 0 = instance a, 1 = instance p
    logic [7:0] data;       // byte presented on acceptance
    logic [7:0] late_data;  // byte driven one cycle after acceptance
  } vec_t;

  vec_t vecs[6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int cyc, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Reference frame: start, 8 data LSB first, optional parity, stop bits.
  function automatic void build_frame(input logic [7:0] d, input bit par, input int nstop,
                                      output logic [11:0] bits, output int nbits);
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    nbits = 9;
    if (par) begin
      bits[9] = ^d;
      nbits   = 10;
    end
    nbits = nbits + nstop;
  endfunction

  // Called at the first cycle after acceptance; returns at the first idle cycle.
  task automatic check_frame(input bit sel, input logic [7:0] d);
    logic [11:0] bits;
    int          nbits;
    logic        s, r, b, dn;
    build_frame(d, sel, sel ? 2 : 1, bits, nbits);
    for (int k = 0; k < nbits * CPB; k++) begin
      s  = sel ? p_serial : a_serial;
      r  = sel ? p_ready  : a_ready;
      b  = sel ? p_busy   : a_busy;
      dn = sel ? p_done   : a_done;
      chk("serial", k + 1, s, bits[k / CPB]);
      chk("busy",   k + 1, b, 1'b1);
      chk("ready",  k + 1, r, 1'b0);
      chk("done",   k + 1, dn, 1'b0);
      tick();
    end
    s  = sel ? p_serial : a_serial;
    r  = sel ? p_ready  : a_ready;
    b  = sel ? p_busy   : a_busy;
    dn = sel ? p_done   : a_done;
    chk("end_done",   nbits * CPB + 1, dn, 1'b1);
    chk("end_ready",  nbits * CPB + 1, r,  1'b1);
    chk("end_busy",   nbits * CPB + 1, b,  1'b0);
    chk("end_serial", nbits * CPB + 1, s,  1'b1);
  endtask

  initial begin
    vecs[0] = '{sel: 1'b0, data: 8'hA5, late_data: 8'hA5};
    vecs[1] = '{sel: 1'b1, data: 8'h07, late_data: 8'h07};
    vecs[2] = '{sel: 1'b1, data: 8'h03, late_data: 8'h03};
    vecs[3] = '{sel: 1'b0, data: 8'h3C, late_data: 8'hC3};
    vecs[4] = '{sel: 1'b1, data: 8'hFF, late_data: 8'h00};
    vecs[5] = '{sel: 1'b0, data: 8'h01, late_data: 8'hFE};

    rst     = 1'b1;
    a_valid = 1'b0;
    p_valid = 1'b0;
    a_data  = 8'h00;
    p_data  = 8'h00;
    tick();
    tick();
    chk("rst_a_serial", 0, a_serial, 1'b1);
    chk("rst_a_ready",  0, a_ready,  1'b1);
    chk("rst_a_busy",   0, a_busy,   1'b0);
    chk("rst_a_done",   0, a_done,   1'b0);
    chk("rst_p_serial", 0, p_serial, 1'b1);
    chk("rst_p_ready",  0, p_ready,  1'b1);
    chk("rst_p_busy",   0, p_busy,   1'b0);
    chk("rst_p_done",   0, p_done,   1'b0);
    rst = 1'b0;
    tick();
    tick();

    // Table-driven single frames
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].sel) begin
        p_valid = 1'b1;
        p_data  = vecs[v].data;
      end else begin
        a_valid = 1'b1;
        a_data  = vecs[v].data;
      end
      tick();
      a_valid = 1'b0;
      p_valid = 1'b0;
      if (vecs[v].sel) p_data = vecs[v].late_data;
      else             a_data = vecs[v].late_data;
      check_frame(vecs[v].sel, vecs[v].data);
      tick();
      tick();
    end

    // Back-to-back with tx_valid held: 0x00 then 0xFF
    a_valid = 1'b1;
    a_data  = 8'h00;
    tick();
    a_data = 8'hFF;
    check_frame(1'b0, 8'h00);
    tick();
    a_valid = 1'b0;
    check_frame(1'b0, 8'hFF);
    tick();

    // Byte presented while busy waits for tx_ready
    a_valid = 1'b1;
    a_data  = 8'hA5;
    tick();
    a_data = 8'h5A;
    check_frame(1'b0, 8'hA5);
    tick();
    a_valid = 1'b0;
    check_frame(1'b0, 8'h5A);
    tick();
    tick();

    // Asynchronous reset during data bit 3 of 0x55 (cycles 17..20)
    a_valid = 1'b1;
    a_data  = 8'h55;
    tick();
    a_valid = 1'b0;
    repeat (17) tick();
    chk("pre_rst_serial", 18, a_serial, 1'b0);
    chk("pre_rst_busy",   18, a_busy,   1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_serial", 18, a_serial, 1'b1);
    chk("async_rst_busy",   18, a_busy,   1'b0);
    chk("async_rst_ready",  18, a_ready,  1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("in_rst_done",   19 + i, a_done,   1'b0);
      chk("in_rst_serial", 19 + i, a_serial, 1'b1);
    end
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("post_rst_done", i, a_done, 1'b0);
      chk("post_rst_idle", i, a_serial, 1'b1);
    end
    a_valid = 1'b1;
    a_data  = 8'h55;
    tick();
    a_valid = 1'b0;
    check_frame(1'b0, 8'h55);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
